// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, start-glitch rejection,
// framing-error strobe and break hold-off. Emits one-cycle byte/strobe pairs.
module uart_rx_byte #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9_600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  generate
    if (CLKS_PER_BIT < 4) begin : g_bad_baud
      $error("uart_rx_byte: CLKS_PER_BIT must be >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          bit_tick;

  assign bit_tick = (clk_cnt == FULL_M1);

  // Shift register holds payload only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == S_DATA && bit_tick)
      shift[bit_cnt] <= rx_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state   <= S_START;
            clk_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (clk_cnt == HALF_M1) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            // Leaving at mid-stop lets a start bit right after the stop bit be caught.
            if (rx_s) begin
              data_out   <= shift;
              data_valid <= 1'b1;
              state      <= S_IDLE;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_BREAK: begin
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte: expected-event queue model checked every cycle,
// plus literal per-test expectations.
module tb_uart_rx_byte;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_byte #(.CLK_FREQ(50_000_000), .BAUD(5_000_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data_out(data_out),
    .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #10 clk = ~clk;

  localparam int CPB     = 10;
  localparam int LAT_MIN = 92;  // 9.5 bit times = 95 clocks, +/- 3
  localparam int LAT_MAX = 98;

  typedef struct {
    bit         err;
    logic [7:0] b;
    int         st;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] cap_b[$];
  int         cap_c[$];
  int         vec = 0;
  int         miss = 0;
  int         cyc = 0;
  int         n_valid = 0;
  int         n_err = 0;
  bit         seen_busy = 0;
  bit         started = 0;
  logic [7:0] last = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: every sent frame queues one expected strobe; the DUT must match it in
  // kind, value and arrival window, and data_out must otherwise hold the last good byte.
  always @(posedge clk) begin
    int   c;
    logic r;
    int   lat;
    cyc++;
    c = cyc;
    r = rst;
    @(negedge clk);
    if (r) begin
      started = 1;
      last    = 8'h00;
      exp_q.delete();
      chk("rst_valid", data_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_data", data_out, 8'h00);
    end else if (started) begin
      if (busy) seen_busy = 1;
      chk("exclusive", data_valid & frame_err, 0);
      if (data_valid) begin
        n_valid++;
        cap_b.push_back(data_out);
        cap_c.push_back(c);
        if (exp_q.size() != 0 && !exp_q[0].err) begin
          lat = c - exp_q[0].st;
          chk("byte", data_out, exp_q[0].b);
          chk("valid_latency_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
          last = exp_q[0].b;
          void'(exp_q.pop_front());
        end else begin
          chk("unexpected_valid", data_valid, 0);
        end
      end else if (frame_err) begin
        n_err++;
        if (exp_q.size() != 0 && exp_q[0].err) begin
          lat = c - exp_q[0].st;
          chk("ferr_latency_ok", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
          void'(exp_q.pop_front());
        end else begin
          chk("unexpected_ferr", frame_err, 0);
        end
      end
      chk("data_hold", data_out, last);
      if (exp_q.size() != 0 && (c - exp_q[0].st) > LAT_MAX) begin
        chk("missing_strobe", exp_q[0].b, 9'h100);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    exp_q.push_back('{err: !stop, b: b, st: cyc});
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop;
    wait_cyc(CPB);
  endtask

  task automatic clear_stats();
    n_valid   = 0;
    n_err     = 0;
    seen_busy = 0;
    cap_b.delete();
    cap_c.delete();
  endtask

  initial begin
    logic [7:0] b67;
    b67 = 8'h67;
    rst = 1'b1;
    rx  = 1'b1;

    // Test 1: reset defaults and quiet idle
    wait_cyc(5);
    chk("t1_data_out", data_out, 8'h00);
    chk("t1_valid", data_valid, 0);
    chk("t1_ferr", frame_err, 0);
    chk("t1_busy", busy, 0);
    rst = 1'b0;
    clear_stats();
    wait_cyc(50);
    chk("t1_no_valid", n_valid, 0);
    chk("t1_no_ferr", n_err, 0);
    chk("t1_busy_idle", busy, 0);

    // Test 2: single byte
    clear_stats();
    send_frame(8'h47, 1'b1);
    wait_cyc(20);
    chk("t2_count", n_valid, 1);
    chk("t2_ferr", n_err, 0);
    chk("t2_data", data_out, 8'h47);

    // Test 3: back-to-back bytes
    clear_stats();
    send_frame(8'h34, 1'b1);
    send_frame(8'h35, 1'b1);
    send_frame(8'h36, 1'b1);
    wait_cyc(20);
    chk("t3_count", n_valid, 3);
    chk("t3_ferr", n_err, 0);
    if (cap_b.size() == 3) begin
      chk("t3_b0", cap_b[0], 8'h34);
      chk("t3_b1", cap_b[1], 8'h35);
      chk("t3_b2", cap_b[2], 8'h36);
      chk("t3_gap01", cap_c[1] - cap_c[0], 100);
      chk("t3_gap12", cap_c[2] - cap_c[1], 100);
    end

    // Test 4: start-bit glitch
    clear_stats();
    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(30);
    chk("t4_busy_pulse", seen_busy, 1);
    chk("t4_busy_now", busy, 0);
    chk("t4_no_valid", n_valid, 0);
    chk("t4_no_ferr", n_err, 0);
    send_frame(8'h50, 1'b1);
    wait_cyc(20);
    chk("t4_count", n_valid, 1);
    chk("t4_data", data_out, 8'h50);

    // Test 5: framing error then break
    clear_stats();
    send_frame(8'h64, 1'b0);
    wait_cyc(30 * CPB);
    chk("t5_ferr_count", n_err, 1);
    chk("t5_no_valid", n_valid, 0);
    chk("t5_data_kept", data_out, 8'h50);
    chk("t5_busy_break", busy, 1);
    rx = 1'b1;
    wait_cyc(20);
    chk("t5_ferr_after", n_err, 1);
    chk("t5_busy_released", busy, 0);
    send_frame(8'h70, 1'b1);
    wait_cyc(20);
    chk("t5_count", n_valid, 1);
    chk("t5_data", data_out, 8'h70);

    // Test 6: reset during data bit 4, sender then releases the line
    clear_stats();
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b67[i];
      wait_cyc(CPB);
    end
    rx = b67[4];
    wait_cyc(5);
    rst = 1'b1;
    wait_cyc(2);
    chk("t6_rst_data", data_out, 8'h00);
    chk("t6_rst_busy", busy, 0);
    rst = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(200);
    chk("t6_no_valid", n_valid, 0);
    chk("t6_no_ferr", n_err, 0);
    chk("t6_data_reset", data_out, 8'h00);
    chk("t6_busy", busy, 0);
    send_frame(8'h44, 1'b1);
    wait_cyc(20);
    chk("t6_count", n_valid, 1);
    chk("t6_data", data_out, 8'h44);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
